pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator and the next generation of the single-channel PWM used by the servo path. It drives `CHANNELS` outputs from one shared `WIDTH`-bit timebase, with edge-aligned or center-aligned counting. New settings (period, mode and all duties) are written in one valid/ready transaction into shadow registers. The shadow contents become active only at a period boundary, so an output never produces a glitched or truncated pulse. It sits between the register/command front end and the output pins (servo and motor drivers).

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_channel.sv | 33 +++
 rtl/pwm_multi.sv | 125 ++++++++++++
 tb/tb_pwm_multi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM generator.
// Imported by the timebase top level and referenced by the per-channel compare.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_CHANNELS = 4;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: active duty register plus the registered compare against
// the shared timebase counter.
module pwm_channel #(
    parameter int WIDTH = pwm_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] duty_new,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] duty_act;
    logic             pwm_p1;

    // Compare stage: the current counter value becomes a pin level one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act <= '0;
            pwm_p1   <= 1'b0;
        end else begin
            pwm_p1 <= enable && (cnt < duty_act);
            if (load) begin
                duty_act <= duty_new;
            end
        end
    end

    assign pwm = pwm_p1;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned timebase, shadowed
// configuration that is copied to the active set only at a period boundary.
module pwm_multi #(
    parameter int CHANNELS = pwm_pkg::DEFAULT_CHANNELS,
    parameter int WIDTH    = pwm_pkg::DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      cfg_mode,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic [CHANNELS*WIDTH-1:0] cfg_duty,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick
);

    import pwm_pkg::*;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    logic [WIDTH-1:0]          cnt_p0;
    logic                      dir_down_p0;
    logic                      tick_p1;
    logic                      pending;

    pwm_mode_t                 shadow_mode;
    logic [WIDTH-1:0]          shadow_period;
    logic [CHANNELS*WIDTH-1:0] shadow_duty;
    pwm_mode_t                 act_mode;
    logic [WIDTH-1:0]          act_period;

    logic                      at_top;
    logic                      boundary;
    logic                      accept;
    logic                      load;

    // A two-count center period has no down ramp, so it wraps like edge mode.
    always_comb begin
        at_top = (cnt_p0 == act_period - ONE);
        if (act_period <= ONE) begin
            boundary = 1'b1;
        end else if (act_mode == PWM_EDGE || act_period == TWO) begin
            boundary = at_top;
        end else begin
            boundary = dir_down_p0 && (cnt_p0 == ONE);
        end
    end

    assign accept    = cfg_valid && !pending;
    assign load      = pending && (!enable || boundary);
    assign cfg_ready = !pending;

    // Shadow capture and shadow-to-active copy; the two can never coincide
    // because capture needs an empty shadow and the copy needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            shadow_mode   <= PWM_EDGE;
            shadow_period <= '0;
            shadow_duty   <= '0;
            act_mode      <= PWM_EDGE;
            act_period    <= '0;
        end else begin
            if (accept) begin
                pending       <= 1'b1;
                shadow_mode   <= pwm_mode_t'(cfg_mode);
                shadow_period <= cfg_period;
                shadow_duty   <= cfg_duty;
            end else if (load) begin
                pending    <= 1'b0;
                act_mode   <= shadow_mode;
                act_period <= shadow_period;
            end
        end
    end

    // Timebase stage: counter and direction; every boundary restarts at 0/up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0      <= '0;
            dir_down_p0 <= 1'b0;
        end else if (!enable || boundary) begin
            cnt_p0      <= '0;
            dir_down_p0 <= 1'b0;
        end else if (act_mode == PWM_EDGE) begin
            cnt_p0 <= cnt_p0 + ONE;
        end else if (dir_down_p0) begin
            cnt_p0 <= cnt_p0 - ONE;
        end else if (at_top) begin
            dir_down_p0 <= 1'b1;
            cnt_p0      <= cnt_p0 - ONE;
        end else begin
            cnt_p0 <= cnt_p0 + ONE;
        end
    end

    // Output stage: tick is aligned with the registered channel compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_p1 <= 1'b0;
        end else begin
            tick_p1 <= enable && boundary;
        end
    end

    assign period_tick = tick_p1;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .load    (load),
            .duty_new(shadow_duty[i*WIDTH +: WIDTH]),
            .cnt     (cnt_p0),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus random traffic,
// all compared every cycle against a phase-index model of the waveform.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_mode;
    logic [W-1:0]  cfg_period;
    logic [CH*W-1:0] cfg_duty;
    logic [CH-1:0] pwm_out;
    logic          period_tick;

    int checks = 0;
    int errors = 0;

    // Model: position within the period plus active/shadow settings as integers.
    int  m_k;
    bit  m_pend;
    bit  act_m, sh_m;
    int  act_p, sh_p;
    int  act_d [CH];
    int  sh_d  [CH];
    logic [CH-1:0] e_pwm;
    logic          e_tick;
    int  hi [CH];
    int  ticks;

    pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int plen();
        if (act_p <= 1) return 1;
        if (!act_m || act_p == 2) return act_p;
        return 2 * act_p - 2;
    endfunction

    function automatic int mcnt();
        if (!act_m || m_k < act_p) return m_k;
        return 2 * act_p - 2 - m_k;
    endfunction

    task automatic model_reset();
        m_k = 0; m_pend = 0; act_m = 0; sh_m = 0; act_p = 0; sh_p = 0;
        for (int i = 0; i < CH; i++) begin act_d[i] = 0; sh_d[i] = 0; end
        e_pwm = '0; e_tick = 1'b0;
    endtask

    task automatic model_step();
        int c;
        bit bnd, ld, acc;
        c   = mcnt();
        bnd = (m_k == plen() - 1);
        for (int i = 0; i < CH; i++) e_pwm[i] = enable && (c < act_d[i]);
        e_tick = enable && bnd;
        ld  = m_pend && (!enable || bnd);
        acc = cfg_valid && !m_pend;
        if (!enable || bnd) m_k = 0; else m_k = m_k + 1;
        if (ld) begin
            act_m = sh_m; act_p = sh_p; m_pend = 0;
            for (int i = 0; i < CH; i++) act_d[i] = sh_d[i];
        end
        if (acc) begin
            sh_m = cfg_mode; sh_p = int'(cfg_period); m_pend = 1;
            for (int i = 0; i < CH; i++) sh_d[i] = int'(cfg_duty[i*W +: W]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("period_tick", 32'(period_tick), 32'(e_tick));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
        ticks += int'(period_tick);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        ticks = 0;
    endtask

    task automatic set_cfg(input bit m, input int p, input int d0, input int d1,
                           input int d2, input int d3);
        cfg_mode   = m;
        cfg_period = W'(p);
        cfg_duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    task automatic offer_once(input bit m, input int p, input int d0, input int d1,
                              input int d2, input int d3);
        set_cfg(m, p, d0, d1, d2, d3);
        cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_applied();
        int n;
        for (n = 0; n < 100 && m_pend; n++) cycle();
        if (m_pend) begin
            checks++; errors++;
            $error("FAIL wait_applied: still pending after %0d cycles", n);
        end
    endtask

    task automatic wait_cnt(input int t);
        int n;
        for (n = 0; n < 100 && mcnt() != t; n++) cycle();
        if (mcnt() != t) begin
            checks++; errors++;
            $error("FAIL wait_cnt: counter %0d never reached %0d", mcnt(), t);
        end
    endtask

    task automatic rand_cfg();
        int p;
        p = $urandom_range(0, 12);
        set_cfg(1'($urandom_range(0, 1)), p, $urandom_range(0, p + 2),
                $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                $urandom_range(0, p + 2));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", 32'(pwm_out), 32'h0);
        chk("reset_tick", 32'(period_tick), 32'h0);
        chk("reset_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // No configuration: outputs stay low while enabled.
        enable = 1'b1;
        repeat (8) cycle();
        chk("unconfigured_pwm", 32'(pwm_out), 32'h0);

        // Edge mode, P=10.
        offer_once(0, 10, 0, 3, 10, 12);
        wait_applied();
        repeat (12) cycle();
        clear_counts();
        repeat (20) cycle();
        chk("edge_ch0_high", 32'(hi[0]), 32'd0);
        chk("edge_ch1_high", 32'(hi[1]), 32'd6);
        chk("edge_ch2_high", 32'(hi[2]), 32'd20);
        chk("edge_ch3_high", 32'(hi[3]), 32'd20);
        chk("edge_ticks", 32'(ticks), 32'd2);

        // Center mode, P=5: 8-cycle period.
        offer_once(1, 5, 2, 0, 5, 1);
        wait_applied();
        repeat (10) cycle();
        clear_counts();
        repeat (16) cycle();
        chk("center_ch0_high", 32'(hi[0]), 32'd6);
        chk("center_ch1_high", 32'(hi[1]), 32'd0);
        chk("center_ch2_high", 32'(hi[2]), 32'd16);
        chk("center_ch3_high", 32'(hi[3]), 32'd2);
        chk("center_ticks", 32'(ticks), 32'd2);

        // Update mid-period: handshake at cnt=5 of P=10, second offer refused.
        offer_once(0, 10, 3, 3, 3, 3);
        wait_applied();
        wait_cnt(5);
        offer_once(0, 4, 2, 2, 2, 2);
        chk("update_ready_low", 32'(cfg_ready), 32'h0);
        set_cfg(1, 7, 1, 1, 1, 1);
        cfg_valid = 1'b1;
        repeat (2) cycle();
        cfg_valid = 1'b0;
        chk("update_blocked", 32'(cfg_ready), 32'h0);
        cycle();
        chk("update_ready_before_wrap", 32'(cfg_ready), 32'h0);
        cycle();
        chk("update_ready_after_wrap", 32'(cfg_ready), 32'h1);
        repeat (2) cycle();
        clear_counts();
        repeat (8) cycle();
        chk("update_ch0_high", 32'(hi[0]), 32'd4);
        chk("update_ticks", 32'(ticks), 32'd2);

        // Disabled handshake, degenerate P=1.
        enable = 1'b0;
        repeat (2) cycle();
        offer_once(0, 1, 1, 1, 1, 1);
        chk("disabled_pending", 32'(cfg_ready), 32'h0);
        cycle();
        chk("disabled_applied", 32'(cfg_ready), 32'h1);
        enable = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            chk("degen_pwm", 32'(pwm_out), 32'hF);
            chk("degen_tick", 32'(period_tick), 32'h1);
        end

        // Handshake on the boundary cycle with nothing pending.
        offer_once(0, 6, 2, 2, 2, 2);
        wait_applied();
        wait_cnt(5);
        offer_once(0, 8, 4, 4, 4, 4);
        repeat (20) cycle();

        // Asynchronous reset mid-run with a configuration pending.
        offer_once(1, 9, 3, 3, 3, 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midreset_pwm", 32'(pwm_out), 32'h0);
        chk("midreset_tick", 32'(period_tick), 32'h0);
        chk("midreset_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle();
        chk("post_reset_pwm", 32'(pwm_out), 32'h0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            cfg_valid = ($urandom_range(0, 3) == 0);
            if (cfg_valid) rand_cfg();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
